// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage MIPS core: ID decode, load-use stall, ID-stage branch
// resolution, and ID/EX -> EX/MEM -> MEM/WB control stages. Optional jal support: PIPE_CTRL_JAL_EN.
module pipe_ctrl_unit #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        inst,
  input  logic               eq,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               flush,
  output logic [1:0]         pc_src,
  output logic               ex_alusrc,
  output logic               ex_regdst,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0]   ex_dst,
  output logic               mem_read,
  output logic               mem_write,
  output logic [REG_W-1:0]   mem_dst,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_W-1:0]   wb_dst,
`ifdef PIPE_CTRL_JAL_EN
  output logic               wb_link,
`endif
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
`ifdef PIPE_CTRL_JAL_EN
  localparam logic [5:0] OP_JAL = 6'b000011;
`endif

  logic [5:0]       opcode;
  logic [REG_W-1:0] rs, rt, rd;
  logic             unused_inst;

  assign opcode      = inst[31:26];
  assign rs          = REG_W'(inst[25:21]);
  assign rt          = REG_W'(inst[20:16]);
  assign rd          = REG_W'(inst[15:11]);
  assign unused_inst = ^inst;

  // Decoded ID-stage bundle
  logic               dec_alusrc, dec_regdst, dec_mem_read, dec_mem_write;
  logic               dec_reg_write, dec_mem_to_reg, dec_link;
  logic [ALUOP_W-1:0] dec_aluop;
  logic [REG_W-1:0]   dec_dst;
  logic               is_beq, is_bne, is_jmp, uses_rs, uses_rt;

  always_comb begin
    dec_alusrc     = 1'b0;
    dec_regdst     = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_link       = 1'b0;
    dec_aluop      = '0;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_jmp         = 1'b0;
    uses_rs        = 1'b1;
    uses_rt        = 1'b0;
    case (opcode)
      OP_R: begin
        dec_regdst    = 1'b1;
        dec_reg_write = 1'b1;
        dec_aluop     = inst[ALUOP_W-1:0];
        uses_rt       = 1'b1;
      end
      OP_LW: begin
        dec_alusrc     = 1'b1;
        dec_mem_read   = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_aluop      = ALUOP_W'(2);
      end
      OP_SW: begin
        dec_alusrc    = 1'b1;
        dec_mem_write = 1'b1;
        dec_aluop     = ALUOP_W'(2);
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        uses_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne  = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J: begin
        is_jmp  = 1'b1;
        uses_rs = 1'b0;
      end
`ifdef PIPE_CTRL_JAL_EN
      OP_JAL: begin
        is_jmp        = 1'b1;
        uses_rs       = 1'b0;
        dec_reg_write = 1'b1;
        dec_link      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign dec_dst = dec_link ? REG_W'(31) : (dec_regdst ? rd : rt);

  // ID/EX, EX/MEM, MEM/WB control registers
  logic               idex_alusrc_q, idex_regdst_q, idex_mem_read_q, idex_mem_write_q;
  logic               idex_reg_write_q, idex_mem_to_reg_q, idex_link_q;
  logic [ALUOP_W-1:0] idex_aluop_q;
  logic [REG_W-1:0]   idex_dst_q;
  logic               exmem_mem_read_q, exmem_mem_write_q, exmem_reg_write_q;
  logic               exmem_mem_to_reg_q, exmem_link_q;
  logic [REG_W-1:0]   exmem_dst_q;
  logic               memwb_reg_write_q, memwb_mem_to_reg_q, memwb_link_q;
  logic [REG_W-1:0]   memwb_dst_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic load_use, taken;

  assign load_use = idex_mem_read_q && (idex_dst_q != '0) &&
                    ((uses_rs && idex_dst_q == rs) || (uses_rt && idex_dst_q == rt));
  assign taken    = (is_beq && eq) || (is_bne && !eq) || is_jmp;

  // A stall holds PC and IF/ID and must not flush, so load_use masks the branch
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush      = 1'b0;
    pc_src     = 2'b00;
    if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (taken) begin
      flush  = 1'b1;
      pc_src = is_jmp ? 2'b10 : 2'b01;
    end
  end

  assign stall_cnt_d = (load_use && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_alusrc_q      <= 1'b0;
      idex_regdst_q      <= 1'b0;
      idex_mem_read_q    <= 1'b0;
      idex_mem_write_q   <= 1'b0;
      idex_reg_write_q   <= 1'b0;
      idex_mem_to_reg_q  <= 1'b0;
      idex_link_q        <= 1'b0;
      idex_aluop_q       <= '0;
      idex_dst_q         <= '0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_link_q       <= 1'b0;
      exmem_dst_q        <= '0;
      memwb_reg_write_q  <= 1'b0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_link_q       <= 1'b0;
      memwb_dst_q        <= '0;
      stall_cnt_q        <= '0;
      flush_cnt_q        <= '0;
    end else begin
      idex_alusrc_q      <= load_use ? 1'b0 : dec_alusrc;
      idex_regdst_q      <= load_use ? 1'b0 : dec_regdst;
      idex_mem_read_q    <= load_use ? 1'b0 : dec_mem_read;
      idex_mem_write_q   <= load_use ? 1'b0 : dec_mem_write;
      idex_reg_write_q   <= load_use ? 1'b0 : dec_reg_write;
      idex_mem_to_reg_q  <= load_use ? 1'b0 : dec_mem_to_reg;
      idex_link_q        <= load_use ? 1'b0 : dec_link;
      idex_aluop_q       <= load_use ? '0 : dec_aluop;
      idex_dst_q         <= load_use ? '0 : dec_dst;
      exmem_mem_read_q   <= idex_mem_read_q;
      exmem_mem_write_q  <= idex_mem_write_q;
      exmem_reg_write_q  <= idex_reg_write_q;
      exmem_mem_to_reg_q <= idex_mem_to_reg_q;
      exmem_link_q       <= idex_link_q;
      exmem_dst_q        <= idex_dst_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_link_q       <= exmem_link_q;
      memwb_dst_q        <= exmem_dst_q;
      stall_cnt_q        <= stall_cnt_d;
      flush_cnt_q        <= flush_cnt_d;
    end
  end

  assign ex_alusrc     = idex_alusrc_q;
  assign ex_regdst     = idex_regdst_q;
  assign ex_aluop      = idex_aluop_q;
  assign ex_dst        = idex_dst_q;
  assign mem_read      = exmem_mem_read_q;
  assign mem_write     = exmem_mem_write_q;
  assign mem_dst       = exmem_dst_q;
  assign wb_reg_write  = memwb_reg_write_q;
  assign wb_mem_to_reg = memwb_mem_to_reg_q;
  assign wb_dst        = memwb_dst_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

`ifdef PIPE_CTRL_JAL_EN
  assign wb_link = memwb_link_q;
`else
  logic unused_link;
  assign unused_link = memwb_link_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios then random instruction streams, checked against
// a cycle-level pipeline model; a second instance with CNT_W=2 exercises counter saturation.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'hFC00_0000;
  logic        eq = 1'b0;

  logic        pc_write, ifid_write, flush;
  logic [1:0]  pc_src;
  logic        ex_alusrc, ex_regdst, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
  logic [2:0]  ex_aluop;
  logic [4:0]  ex_dst, mem_dst, wb_dst;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_flush;
  logic [1:0]  s_pc_src;
  logic        s_ex_alusrc, s_ex_regdst, s_mem_read, s_mem_write, s_wb_reg_write, s_wb_mem_to_reg;
  logic [2:0]  s_ex_aluop;
  logic [4:0]  s_ex_dst, s_mem_dst, s_wb_dst;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
`ifdef PIPE_CTRL_JAL_EN
  logic        wb_link, s_wb_link;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .eq(eq),
    .pc_write(pc_write), .ifid_write(ifid_write), .flush(flush), .pc_src(pc_src),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_aluop(ex_aluop), .ex_dst(ex_dst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dst(mem_dst),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
`ifdef PIPE_CTRL_JAL_EN
    .wb_link(wb_link),
`endif
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inst(inst), .eq(eq),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .flush(s_flush), .pc_src(s_pc_src),
    .ex_alusrc(s_ex_alusrc), .ex_regdst(s_ex_regdst), .ex_aluop(s_ex_aluop), .ex_dst(s_ex_dst),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_dst(s_mem_dst),
    .wb_reg_write(s_wb_reg_write), .wb_mem_to_reg(s_wb_mem_to_reg), .wb_dst(s_wb_dst),
`ifdef PIPE_CTRL_JAL_EN
    .wb_link(s_wb_link),
`endif
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic       alusrc, regdst;
    logic [2:0] aluop;
    logic [4:0] dst;
    logic       mem_read, mem_write, reg_write, mem_to_reg, link;
  } bund_t;

  bund_t pipe_m [3];  // [0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB
  int    stall_n, flush_n;
  int    check_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  logic  obs_flush, obs_pc_write;
  logic [1:0] obs_pc_src;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  function automatic bit is_jal(logic [5:0] op);
`ifdef PIPE_CTRL_JAL_EN
    return op == 6'h03;
`else
    return (op == 6'h03) && 1'b0;
`endif
  endfunction

  function automatic bund_t m_decode(logic [31:0] i);
    bund_t b;
    logic [5:0] op;
    b  = '0;
    op = i[31:26];
    if (op == 6'h00) begin
      b.regdst = 1; b.reg_write = 1; b.aluop = i[2:0];
    end else if (op == 6'h23) begin
      b.alusrc = 1; b.mem_read = 1; b.reg_write = 1; b.mem_to_reg = 1; b.aluop = 3'd2;
    end else if (op == 6'h2b) begin
      b.alusrc = 1; b.mem_write = 1; b.aluop = 3'd2;
    end else if (is_jal(op)) begin
      b.reg_write = 1; b.link = 1;
    end
    b.dst = b.link ? 5'd31 : (b.regdst ? i[15:11] : i[20:16]);
    return b;
  endfunction

  function automatic bit m_reads(logic [31:0] i, logic [4:0] r);
    logic [5:0] op;
    bit rs_rd, rt_rd;
    op    = i[31:26];
    rs_rd = !(op == 6'h02 || is_jal(op));
    rt_rd = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
    return (rs_rd && i[25:21] == r) || (rt_rd && i[20:16] == r);
  endfunction

  function automatic logic [31:0] sat(int n, int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, int funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check ID-stage outputs, clock, update model, check stages
  task automatic step(input logic [31:0] i, input logic e, input logic r);
    bit lu, tk;
    logic [5:0] op;
    logic [1:0] src;
    bund_t b;
    @(negedge clk);
    inst = i; eq = e; rst_n = r;
    #1;
    op  = i[31:26];
    lu  = pipe_m[0].mem_read && pipe_m[0].dst != 5'd0 && m_reads(i, pipe_m[0].dst);
    tk  = (op == 6'h04 && e) || (op == 6'h05 && !e) || op == 6'h02 || is_jal(op);
    src = (lu || !tk) ? 2'b00 : ((op == 6'h02 || is_jal(op)) ? 2'b10 : 2'b01);
    chk("pc_write", pc_write, !lu);
    chk("ifid_write", ifid_write, !lu);
    chk("flush", flush, tk && !lu);
    chk("pc_src", pc_src, src);
    obs_flush = flush; obs_pc_src = pc_src; obs_pc_write = pc_write;
    @(posedge clk);
    if (!r) begin
      pipe_m[0] = '0; pipe_m[1] = '0; pipe_m[2] = '0;
      stall_n = 0; flush_n = 0;
    end else begin
      pipe_m[2] = pipe_m[1];
      pipe_m[1] = pipe_m[0];
      pipe_m[0] = lu ? bund_t'('0) : m_decode(i);
      stall_n += int'(lu);
      flush_n += int'(tk && !lu);
    end
    #1;
    b = pipe_m[0];
    chk("ex_alusrc", ex_alusrc, b.alusrc);
    chk("ex_regdst", ex_regdst, b.regdst);
    chk("ex_aluop", ex_aluop, b.aluop);
    chk("ex_dst", ex_dst, b.dst);
    b = pipe_m[1];
    chk("mem_read", mem_read, b.mem_read);
    chk("mem_write", mem_write, b.mem_write);
    chk("mem_dst", mem_dst, b.dst);
    b = pipe_m[2];
    chk("wb_reg_write", wb_reg_write, b.reg_write);
    chk("wb_mem_to_reg", wb_mem_to_reg, b.mem_to_reg);
    chk("wb_dst", wb_dst, b.dst);
`ifdef PIPE_CTRL_JAL_EN
    chk("wb_link", wb_link, b.link);
`endif
    chk("stall_cnt", stall_cnt, sat(stall_n, 65535));
    chk("flush_cnt", flush_cnt, sat(flush_n, 65535));
    chk("sat_stall_cnt", s_stall_cnt, sat(stall_n, 3));
    chk("sat_flush_cnt", s_flush_cnt, sat(flush_n, 3));
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
    pipe_m[0] = '0; pipe_m[1] = '0; pipe_m[2] = '0;
    stall_n = 0; flush_n = 0;

    // Reset held for two edges with lw in ID
    step(i_ins(6'h23, 1, 2, 0), 0, 0);
    step(i_ins(6'h23, 1, 2, 0), 0, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_ex_alusrc", ex_alusrc, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    step(i_ins(6'h23, 1, 2, 0), 0, 1);
    step(NOP, 0, 1);
    chk("lw_mem_read_lat2", mem_read, 1);

    // R-type add rd=3
    step(NOP, 0, 0);
    step(r_ins(1, 2, 3, 6'h20), 0, 1);
    chk("add_ex_regdst", ex_regdst, 1);
    chk("add_ex_dst", ex_dst, 3);
    chk("add_ex_aluop", ex_aluop, 0);
    step(NOP, 0, 1);
    step(NOP, 0, 1);
    chk("add_wb_reg_write", wb_reg_write, 1);
    chk("add_wb_dst", wb_dst, 3);

    // lw $2 then dependent add
    step(NOP, 0, 0);
    step(i_ins(6'h23, 1, 2, 4), 0, 1);
    step(r_ins(2, 3, 5, 6'h20), 0, 1);
    chk("lu_pc_write", obs_pc_write, 0);
    chk("lu_bubble_regdst", ex_regdst, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    step(r_ins(2, 3, 5, 6'h20), 0, 1);
    chk("lu_after_pc_write", obs_pc_write, 1);
    chk("lu_after_ex_dst", ex_dst, 5);

    // beq taken, bne not taken
    step(NOP, 0, 0);
    step(i_ins(6'h04, 1, 2, 8), 1, 1);
    chk("beq_flush", obs_flush, 1);
    chk("beq_pc_src", obs_pc_src, 1);
    chk("beq_flush_cnt", flush_cnt, 1);
    step(i_ins(6'h05, 1, 2, 8), 1, 1);
    chk("bne_flush", obs_flush, 0);
    chk("bne_pc_src", obs_pc_src, 0);

    // lw $4 then beq on $4: stall first, then resolve
    step(NOP, 0, 0);
    step(i_ins(6'h23, 1, 4, 0), 0, 1);
    step(i_ins(6'h04, 4, 5, 8), 1, 1);
    chk("lub_flush_c1", obs_flush, 0);
    chk("lub_pc_write_c1", obs_pc_write, 0);
    step(i_ins(6'h04, 4, 5, 8), 1, 1);
    chk("lub_flush_c2", obs_flush, 1);
    chk("lub_pc_src_c2", obs_pc_src, 1);
    chk("lub_stall_cnt", stall_cnt, 1);
    chk("lub_flush_cnt", flush_cnt, 1);

    // Five stall events: 2-bit counter holds at 3
    step(NOP, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(i_ins(6'h23, 1, 2, 0), 0, 1);
      step(r_ins(3, 2, 6, 6'h22), 0, 1);
    end
    chk("sat_stall_hold", s_stall_cnt, 3);
    chk("full_stall_5", stall_cnt, 5);

    // Random instruction stream over a small register set to provoke hazards
    step(NOP, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ri;
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      ri = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'd0, 6'($urandom_range(0, 63))};
      step(ri, 1'($urandom_range(0, 1)), ($urandom_range(0, 59) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
